// File: rtl/lane_combat_engine.sv
// Game-logic core for the lawn: per-lane zombie and pea positions, hit points, collisions,
// kill count and the IDLE/RUN/WIN/LOSE level FSM, with a valid/ready fire request port.
module lane_combat_engine #(
  parameter int unsigned NUM_LANES     = 5,
  parameter int unsigned PEAS_PER_LANE = 4,
  parameter int unsigned ZOMBIE_HP     = 5,
  parameter int unsigned TICK_DIV      = 500000,
  parameter int unsigned ZOMBIE_STEP   = 1,
  parameter int unsigned PEA_STEP      = 4,
  parameter int unsigned SPAWN_X       = 799,
  parameter int unsigned PEA_SPAWN_X   = 160,
  parameter int unsigned SCREEN_W      = 800,
  localparam int unsigned LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    fire_valid,
  input  logic [LANE_W-1:0]                       fire_lane,
  output logic                                    fire_ready,
  output logic [10*NUM_LANES-1:0]                 zombie_x,
  output logic [NUM_LANES-1:0]                    zombie_alive,
  output logic [10*NUM_LANES*PEAS_PER_LANE-1:0]   pea_x,
  output logic [NUM_LANES*PEAS_PER_LANE-1:0]      pea_valid,
  output logic [15:0]                             zombies_killed,
  output logic [1:0]                              game_state
);

  localparam int unsigned NumPeas = NUM_LANES * PEAS_PER_LANE;
  localparam int unsigned IdxW    = (NumPeas > 1) ? $clog2(NumPeas) : 1;
  localparam int unsigned CntW    = $clog2(TICK_DIV);

  localparam logic [CntW-1:0] TickLast  = CntW'(TICK_DIV - 1);
  localparam logic [9:0]      SpawnX    = 10'(SPAWN_X);
  localparam logic [9:0]      PeaSpawnX = 10'(PEA_SPAWN_X);
  localparam logic [9:0]      ZStep     = 10'(ZOMBIE_STEP);
  localparam logic [10:0]     PStep     = 11'(PEA_STEP);
  localparam logic [10:0]     ScreenW   = 11'(SCREEN_W);
  localparam logic [3:0]      HpInit    = 4'(ZOMBIE_HP);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StWin  = 2'b10,
    StLose = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [9:0]          zx_q [NUM_LANES];
  logic [9:0]          zx_d [NUM_LANES];
  logic [3:0]          hp_q [NUM_LANES];
  logic [3:0]          hp_d [NUM_LANES];
  logic [NUM_LANES-1:0] alive_q, alive_d;
  logic [9:0]          px_q [NumPeas];
  logic [9:0]          px_d [NumPeas];
  logic [NumPeas-1:0]  pv_q, pv_d;
  logic [15:0]         kills_q, kills_d;

  logic                lane_ok;
  logic [NUM_LANES-1:0] lane_free;
  logic [IdxW-1:0]     lane_slot [NUM_LANES];
  logic [IdxW-1:0]     fire_idx;

  logic                tick;
  logic                lose;
  logic [9:0]          z_new;
  logic [10:0]         p_new;
  logic [3:0]          hits;

  // Lowest free slot per lane, from the registered occupancy only.
  always_comb begin
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      lane_free[l] = 1'b0;
      lane_slot[l] = '0;
      for (int s = int'(PEAS_PER_LANE) - 1; s >= 0; s--) begin
        if (!pv_q[l*int'(PEAS_PER_LANE)+s]) begin
          lane_free[l] = 1'b1;
          lane_slot[l] = IdxW'(l*int'(PEAS_PER_LANE)+s);
        end
      end
    end
    lane_ok    = 32'(fire_lane) < NUM_LANES;
    fire_ready = (state_q == StRun) && lane_ok && lane_free[fire_lane];
    fire_idx   = lane_slot[fire_lane];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zx_d    = zx_q;
    hp_d    = hp_q;
    alive_d = alive_q;
    px_d    = px_q;
    pv_d    = pv_q;
    kills_d = kills_q;
    tick    = 1'b0;
    lose    = 1'b0;
    z_new   = '0;
    p_new   = '0;
    hits    = '0;

    case (state_q)
      StIdle, StWin, StLose: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          alive_d = '1;
          pv_d    = '0;
          kills_d = '0;
          for (int l = 0; l < int'(NUM_LANES); l++) begin
            zx_d[l] = SpawnX;
            hp_d[l] = HpInit;
          end
          for (int p = 0; p < int'(NumPeas); p++) px_d[p] = '0;
        end
      end
      StRun: begin
        tick  = (cnt_q == TickLast);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          for (int l = 0; l < int'(NUM_LANES); l++) begin
            z_new = (zx_q[l] >= ZStep) ? zx_q[l] - ZStep : '0;
            if (alive_q[l]) zx_d[l] = z_new;
            hits = '0;
            for (int s = 0; s < int'(PEAS_PER_LANE); s++) begin
              if (pv_q[l*int'(PEAS_PER_LANE)+s]) begin
                p_new = {1'b0, px_q[l*int'(PEAS_PER_LANE)+s]} + PStep;
                if (p_new >= ScreenW) begin
                  pv_d[l*int'(PEAS_PER_LANE)+s] = 1'b0;
                  px_d[l*int'(PEAS_PER_LANE)+s] = '0;
                end else if (alive_q[l] && (p_new >= {1'b0, z_new})) begin
                  // Every pea reaching the zombie this tick is consumed and lands a hit.
                  pv_d[l*int'(PEAS_PER_LANE)+s] = 1'b0;
                  px_d[l*int'(PEAS_PER_LANE)+s] = '0;
                  hits = hits + 4'd1;
                end else begin
                  px_d[l*int'(PEAS_PER_LANE)+s] = p_new[9:0];
                end
              end
            end
            if (alive_q[l]) begin
              if (z_new == '0) lose = 1'b1;
              if ((hits != '0) && (hits >= hp_q[l])) begin
                hp_d[l]    = '0;
                alive_d[l] = 1'b0;
                if (kills_d != 16'hFFFF) kills_d = kills_d + 16'd1;
              end else begin
                hp_d[l] = hp_q[l] - hits;
              end
            end
          end
          // A zombie at the house beats a simultaneous clear of the lawn.
          if (lose) begin
            state_d = StLose;
          end else if (alive_d == '0) begin
            state_d = StWin;
          end
        end
        // The chosen slot is free in the registered state, so the tick logic never touched it.
        if (fire_valid && fire_ready) begin
          pv_d[fire_idx] = 1'b1;
          px_d[fire_idx] = PeaSpawnX;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      alive_q <= '0;
      pv_q    <= '0;
      kills_q <= '0;
      for (int l = 0; l < int'(NUM_LANES); l++) begin
        zx_q[l] <= SpawnX;
        hp_q[l] <= HpInit;
      end
      for (int p = 0; p < int'(NumPeas); p++) px_q[p] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alive_q <= alive_d;
      pv_q    <= pv_d;
      kills_q <= kills_d;
      zx_q    <= zx_d;
      hp_q    <= hp_d;
      px_q    <= px_d;
    end
  end

  always_comb begin
    zombie_x = '0;
    pea_x    = '0;
    for (int l = 0; l < int'(NUM_LANES); l++) zombie_x[10*l +: 10] = zx_q[l];
    for (int p = 0; p < int'(NumPeas); p++) pea_x[10*p +: 10] = px_q[p];
    zombie_alive   = alive_q;
    pea_valid      = pv_q;
    zombies_killed = kills_q;
    game_state     = state_q;
  end

endmodule
